mux_rr_reg: RTL and testbench

- Parametrised successor to the datapath 2:1 selector: an N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Three selection modes: forced select (legacy `s`-style steering), fixed priority and round-robin.
- Sits between multiple producers (e.g. writeback sources or bus masters) and a single consumer that may stall.

---
 rtl/mux_rr_reg.sv | 120 ++++++++++++
 tb/tb_mux_rr_reg.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg
//   N-channel, WIDTH-bit multiplexer with a registered output stage and
//   valid/ready handshakes on every input channel and on the output.
//   The channel is chosen by one of three modes:
//     00 forced          : channel `sel` (legacy 2:1 selector steering)
//     01 fixed priority  : lowest-index valid channel
//     1x round-robin     : first valid channel after the last one granted
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   mode       selection mode (see above)
//   sel        channel index used in forced mode
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   out_data   registered selected data
//   out_ch     registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  consumer ready
// -----------------------------------------------------------------------------
module mux_rr_reg #(
  parameter int WIDTH  = 5,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  last_gnt;
  logic              load;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;
  int                rr_idx;
  logic              rr_found;

  logic [WIDTH-1:0]  data_p0;
  logic [SEL_W-1:0]  ch_p0;
  logic              vld_p0;

  // Grant: at most one bit set, and only for a channel that is valid.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    rr_idx   = 0;
    rr_found = 1'b0;
    if (mode == 2'b00) begin
      // An out-of-range sel matches no loop index, so nothing is granted.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else if (mode == 2'b01) begin
      // Descending scan: the last hit written is the lowest valid index.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          gnt     = '0;
          gnt[i]  = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Search starts just after last_gnt and wraps modulo NUM_CH, so the
      // channel granted last has the lowest priority this cycle.
      for (int k = 1; k <= NUM_CH; k++) begin
        rr_idx = (int'(last_gnt) + k) % NUM_CH;
        if (!rr_found && in_valid[rr_idx]) begin
          rr_found     = 1'b1;
          gnt[rr_idx]  = 1'b1;
          gnt_idx      = SEL_W'(rr_idx);
        end
      end
    end
  end

  // The output register can take a word when empty or being popped this cycle.
  assign load     = ~vld_p0 | out_ready;
  assign in_ready = (rst || !load) ? '0 : gnt;
  assign xfer     = |in_ready;
  assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

  // ---- stage p0: registered output word ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      ch_p0    <= '0;
      last_gnt <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      vld_p0  <= 1'b1;
      data_p0 <= sel_data;
      ch_p0   <= gnt_idx;
      if (mode[1]) begin
        last_gnt <= gnt_idx;
      end
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_data  = data_p0;
  assign out_ch    = ch_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_mux_rr_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_reg
//   Self-checking bench for mux_rr_reg (WIDTH=5, NUM_CH=4, SEL_W=2).
//   A cycle model predicts in_ready and queues the expected output word on
//   every predicted transfer; the queue head is compared against the DUT
//   output while it is valid. Scenario tasks add targeted inline checks.
// -----------------------------------------------------------------------------
module tb_mux_rr_reg;

  localparam int W   = 5;
  localparam int NCH = 4;
  localparam int SW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     mode = 2'b10;
  logic [SW-1:0]  sel = '0;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH-1:0] in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready = 1'b1;

  logic [W-1:0]   chv [NCH];
  int             n_tests = 0;
  int             n_fail  = 0;
  logic           mon_en  = 1'b0;

  // model state
  logic           m_vld  = 1'b0;
  int             m_last = NCH - 1;
  logic [W+SW-1:0] q [$];

  mux_rr_reg #(.WIDTH(W), .NUM_CH(NCH), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    chv[0] = 5'h03;
    chv[1] = 5'h0A;
    chv[2] = 5'h15;
    chv[3] = 5'h1F;
  end
  assign in_data = {chv[3], chv[2], chv[1], chv[0]};

  function automatic int model_grant(logic [1:0] md, logic [SW-1:0] s,
                                     logic [NCH-1:0] v, int last);
    if (md == 2'b00) begin
      return v[s] ? int'(s) : -1;
    end else if (md == 2'b01) begin
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 1; k <= NCH; k++) begin
      if (v[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  // Scoreboard: check at the falling edge, then advance the model to the
  // state the DUT will hold after the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int g;
      logic ld, pop;
      logic [NCH-1:0] exp_rdy;
      ld  = !m_vld || out_ready;
      g   = model_grant(mode, sel, in_valid, m_last);
      exp_rdy = (rst || !ld || g < 0) ? '0 : NCH'(1) << g;
      n_tests++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL sb_in_ready got %b expected %b at %0t", in_ready, exp_rdy, $time);
      end
      n_tests++;
      if (out_valid !== m_vld) begin
        n_fail++;
        $display("FAIL sb_out_valid got %b expected %b at %0t", out_valid, m_vld, $time);
      end
      if (m_vld) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_queue_empty got 0 entries expected 1 at %0t", $time);
        end else if ({out_data, out_ch} !== q[0]) begin
          n_fail++;
          $display("FAIL sb_word got data=%h ch=%0d expected data=%h ch=%0d at %0t",
                   out_data, out_ch, q[0][W+SW-1:SW], q[0][SW-1:0], $time);
        end
      end
      if (rst) begin
        m_vld  = 1'b0;
        m_last = NCH - 1;
        q.delete();
      end else begin
        pop = m_vld && out_ready;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (ld && g >= 0) begin
          q.push_back({chv[g], SW'(g)});
          m_vld = 1'b1;
          if (mode[1]) m_last = g;
        end else if (pop) begin
          m_vld = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 2'b10;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_data, out_ch, in_ready} !== {1'b0, 5'h00, 2'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b d=%h ch=%0d rdy=%b expected v=0 d=00 ch=0 rdy=0000",
               out_valid, out_data, out_ch, in_ready);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_ready got %b expected 0001", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 5'h03, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_first_word got v=%b d=%h ch=%0d expected v=1 d=03 ch=0",
               out_valid, out_data, out_ch);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_forced();
    mode = 2'b00;
    sel = 2'd2;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL forced_ready_sel2 got %b expected 0100", in_ready);
    end
    tick();
    n_tests++;
    if ({out_data, out_ch} !== {5'h15, 2'd2}) begin
      n_fail++;
      $display("FAIL forced_word_sel2 got d=%h ch=%0d expected d=15 ch=2", out_data, out_ch);
    end
    sel = 2'd1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL forced_ready_sel1 got %b expected 0010", in_ready);
    end
    tick();
    n_tests++;
    if ({out_data, out_ch} !== {5'h0A, 2'd1}) begin
      n_fail++;
      $display("FAIL forced_word_sel1 got d=%h ch=%0d expected d=0a ch=1", out_data, out_ch);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_fixed();
    mode = 2'b01;
    in_valid = 4'b1010;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL fixed_ready cycle %0d got %b expected 0010", c, in_ready);
      end
      tick();
      n_tests++;
      if (out_ch !== 2'd1) begin
        n_fail++;
        $display("FAIL fixed_ch cycle %0d got %0d expected 1", c, out_ch);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 2'b10;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== SW'(k % NCH)) begin
        n_fail++;
        $display("FAIL rr_all step %0d got v=%b ch=%0d expected v=1 ch=%0d",
                 k, out_valid, out_ch, k % NCH);
      end
    end
    mode = 2'b11;
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      logic [SW-1:0] exp_ch;
      exp_ch = (k % 2 == 0) ? 2'd0 : 2'd3;
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch) begin
        n_fail++;
        $display("FAIL rr_1001 step %0d got v=%b ch=%0d expected v=1 ch=%0d",
                 k, out_valid, out_ch, exp_ch);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 2'b10;
    in_valid = 4'b1000;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_ready cycle %0d got %b expected 0000", c, in_ready);
      end
      tick();
      n_tests++;
      if ({out_valid, out_data, out_ch} !== {1'b1, 5'h1F, 2'd3}) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got v=%b d=%h ch=%0d expected v=1 d=1f ch=3",
                 c, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL release_ready got %b expected 0001", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 5'h03, 2'd0}) begin
      n_fail++;
      $display("FAIL release_word got v=%b d=%h ch=%0d expected v=1 d=03 ch=0",
               out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_reset_stall();
    // Advance the pointer to ch1 so a restart at ch0 is observable.
    mode = 2'b10;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rststall_ready got %b expected 0000", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rststall_valid got %b expected 0", out_valid);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rststall_restart_ready got %b expected 0001", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_ch} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL rststall_restart_word got v=%b ch=%0d expected v=1 ch=0", out_valid, out_ch);
    end
    in_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_forced();
    test_fixed();
    test_round_robin();
    test_back_to_back();
    test_reset_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
